tiny_alu: RTL and testbench
===========================

TINY_ALU -- requirements
Module: tiny_alu

Interface
REQ-001 Port clk  input  1  single clock; all state updates on rising edge.
REQ-002 Port reset_n  input  1  asynchronous, active-low reset.
REQ-003 Port start  input  1  initiator request; held high until done is seen.
REQ-004 Port A  input  8  operand A (operand_t).
REQ-005 Port B  input  8  operand B (operand_t).
REQ-006 Port opcode  input  3  operation select (op_t).
REQ-007 Port done  output  1  one-cycle completion pulse.
REQ-008 Port result  output  16  operation result (result_t), registered.
REQ-009 Parameter MUL_LATENCY, default 3, meaning MUL edges from acceptance to done; legal range 2..4.

Function
REQ-010 States IDLE, EXEC, MULW; IDLE is entered on reset.
REQ-011 In IDLE, start sampled high at edge k shall capture A, B, and opcode; later input changes are ignored until done.
REQ-012 Non-MUL ops: IDLE->EXEC at edge k; done=1 and result valid from edge k+1 for exactly one cycle; then EXEC->IDLE.
REQ-013 MUL: IDLE->MULW at edge k; done=1 and result valid from edge k+MUL_LATENCY for one cycle; then MULW->IDLE.
REQ-014 A new op is accepted only in IDLE; start high during EXEC/MULW or during the done cycle is ignored; start high at the edge after done starts a new op.
REQ-015 Encoding: NOP=0, ADD=1, SUB=2, NOT=3, XOR=4, AND=5, MUL=6, INC=7; all codes are legal.
REQ-016 Arithmetic in 16 bits with operands zero-extended: ADD=A+B; SUB=A-B mod 2^16; NOT=~{8'h00,A}; XOR=A^B; AND=A&B; MUL=A*B; INC=A+B+1.
REQ-017 NOP shall complete with one-cycle latency and result 16'h0000.
REQ-018 result shall hold its last value until the next done edge; done shall never be high for two consecutive cycles.

Reset
REQ-019 When reset_n=0, asynchronously: state=IDLE, done=0, result=16'h0000, captured operands and MUL pipeline cleared.
REQ-020 Reset asserted mid-operation abandons the op; no done pulse is produced for it after reset release.
REQ-021 The first acceptance is possible at the first rising edge with reset_n=1 and start=1.

Configuration
REQ-022 Macro TINY_ALU_MUL_EN defined: MUL uses the pipelined multiplier per REQ-013.
REQ-023 Macro TINY_ALU_MUL_EN undefined: no multiplier is instantiated; MUL completes per REQ-012 with result 16'h0000; MULW is unused.

Structure
REQ-024 alu_pkg shall hold op_t (3-bit enum), operand_t (8-bit), result_t (16-bit), and the MUL_LATENCY default constant.
REQ-025 Sub-module tiny_alu_mul: MUL_LATENCY-stage pipelined 8x8->16 multiplier with valid-in/valid-out and async active-low reset; instantiated only under TINY_ALU_MUL_EN.

Verification
REQ-026 Reset 5 cycles, then ADD A=200 B=100 -> done one edge after acceptance, result=300.
REQ-027 SUB A=3 B=5 -> result=16'hFFFE; NOT A=8'h0F -> result=16'hFFF0.
REQ-028 MUL A=255 B=255 with TINY_ALU_MUL_EN -> done exactly 3 edges after acceptance, result=65025; without the macro -> 1 edge, result=0.
REQ-029 INC A=255 B=255 -> result=511; NOP -> done after 1 edge, result=0; start held high through done -> next op accepted at the following edge only.
REQ-030 reset_n pulsed low during MULW -> done=0 and result=0 immediately, no done after release; a subsequent ADD 1+1 -> result=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the tiny_alu slice: opcode enum, operand
// and result widths, and the default multiplier latency.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_NOT = 3'd3,
        OP_XOR = 3'd4,
        OP_AND = 3'd5,
        OP_MUL = 3'd6,
        OP_INC = 3'd7
    } op_t;

    typedef logic [7:0]  operand_t;
    typedef logic [15:0] result_t;

    localparam int MUL_LATENCY_DEF = 3;

endpackage

// File: rtl/tiny_alu_mul.sv
// tiny_alu_mul: MUL_LATENCY-stage pipelined 8x8->16 unsigned multiplier with
// valid-in/valid-out. Only built when TINY_ALU_MUL_EN is defined.
// Stage p0 forms two 4-bit partial products, stage p1 sums them, and any
// remaining stages are a plain delay line so the total latency matches.
`ifdef TINY_ALU_MUL_EN
module tiny_alu_mul
    import alu_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     vld_in,
    input  operand_t a,
    input  operand_t b,
    output logic     vld_out,
    output result_t  prod
);

    localparam int DLY = MUL_LATENCY - 2;

    logic [11:0] pp_lo_p0;
    logic [11:0] pp_hi_p0;
    logic        vld_p0;
    result_t     prod_p1;
    logic        vld_p1;

    // Stage p0: low and high nibble partial products of B
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp_lo_p0 <= '0;
            pp_hi_p0 <= '0;
            vld_p0   <= 1'b0;
        end else begin
            pp_lo_p0 <= {4'h0, a} * {8'h00, b[3:0]};
            pp_hi_p0 <= {4'h0, a} * {8'h00, b[7:4]};
            vld_p0   <= vld_in;
        end
    end

    // Stage p1: combine partial products into the full 16-bit product
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            prod_p1 <= {4'h0, pp_lo_p0} + {pp_hi_p0, 4'h0};
            vld_p1  <= vld_p0;
        end
    end

    if (DLY == 0) begin : g_no_dly
        assign prod    = prod_p1;
        assign vld_out = vld_p1;
    end else begin : g_dly
        result_t        prod_dly [DLY];
        logic [DLY-1:0] vld_dly;

        // Stages p2..: delay line padding the product out to MUL_LATENCY
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DLY; i++) begin
                    prod_dly[i] <= '0;
                    vld_dly[i]  <= 1'b0;
                end
            end else begin
                prod_dly[0] <= prod_p1;
                vld_dly[0]  <= vld_p1;
                for (int i = 1; i < DLY; i++) begin
                    prod_dly[i] <= prod_dly[i-1];
                    vld_dly[i]  <= vld_dly[i-1];
                end
            end
        end

        assign prod    = prod_dly[DLY-1];
        assign vld_out = vld_dly[DLY-1];
    end

endmodule
`endif

// File: rtl/tiny_alu.sv
// tiny_alu: start/done handshake ALU with 8-bit operands and a registered
// 16-bit result. Non-MUL ops finish one edge after acceptance.
// Optional feature macro TINY_ALU_MUL_EN: when defined, MUL runs through the
// pipelined tiny_alu_mul and finishes MUL_LATENCY edges after acceptance;
// when undefined, MUL behaves like a one-cycle op returning zero.
module tiny_alu
    import alu_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  operand_t   A,
    input  operand_t   B,
    input  logic [2:0] opcode,
    output logic       done,
    output result_t    result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULW = 2'd2
    } state_t;

    if (MUL_LATENCY < 2 || MUL_LATENCY > 4) begin : g_bad_latency
        $error("tiny_alu: MUL_LATENCY must be in 2..4");
    end

    state_t   state;
    operand_t a_q;
    operand_t b_q;
    op_t      op_q;
    logic     accept;

    // A request is taken only from IDLE and never in the cycle done is high,
    // so a start held across done waits one extra edge before re-acceptance.
    assign accept = (state == IDLE) && start && !done;

    function automatic result_t alu_calc(op_t op, operand_t a, operand_t b);
        result_t ax;
        result_t bx;
        ax = {8'h00, a};
        bx = {8'h00, b};
        case (op)
            OP_ADD:  return ax + bx;
            OP_SUB:  return ax - bx;
            OP_NOT:  return ~ax;
            OP_XOR:  return ax ^ bx;
            OP_AND:  return ax & bx;
            OP_INC:  return ax + bx + 16'd1;
            default: return '0;
        endcase
    endfunction

`ifdef TINY_ALU_MUL_EN
    logic    mul_vld;
    result_t mul_prod;
    logic    mul_start;

    // The multiplier samples the live operands on the acceptance edge itself.
    assign mul_start = accept && (op_t'(opcode) == OP_MUL);

    tiny_alu_mul #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .vld_in  (mul_start),
        .a       (A),
        .b       (B),
        .vld_out (mul_vld),
        .prod    (mul_prod)
    );
`endif

    // Control FSM: capture on accept, complete with a one-cycle done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_NOP;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= A;
                        b_q  <= B;
                        op_q <= op_t'(opcode);
`ifdef TINY_ALU_MUL_EN
                        state <= (op_t'(opcode) == OP_MUL) ? MULW : EXEC;
`else
                        state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    done   <= 1'b1;
                    result <= alu_calc(op_q, a_q, b_q);
                    state  <= IDLE;
                end
                MULW: begin
`ifdef TINY_ALU_MUL_EN
                    if (mul_vld) begin
                        done   <= 1'b1;
                        result <= mul_prod;
                        state  <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_alu.sv
// Directed testbench for tiny_alu; expected values are hand-computed.
// Follows the TINY_ALU_MUL_EN build setting for MUL expectations.
module tb_tiny_alu;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  opcode;
    logic        done;
    logic [15:0] result;

    int n_checks;
    int n_fail;

    localparam logic [2:0] C_NOP = 3'd0, C_ADD = 3'd1, C_SUB = 3'd2, C_NOT = 3'd3;
    localparam logic [2:0] C_XOR = 3'd4, C_AND = 3'd5, C_MUL = 3'd6, C_INC = 3'd7;

`ifdef TINY_ALU_MUL_EN
    localparam int          EXP_MUL_LAT = 3;
    localparam logic [15:0] EXP_MUL_RES = 16'd65025;
`else
    localparam int          EXP_MUL_LAT = 1;
    localparam logic [15:0] EXP_MUL_RES = 16'd0;
`endif

    tiny_alu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .opcode  (opcode),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] res);
        @(negedge clk);
        start = 1'b1; A = a; B = b; opcode = op;
        @(posedge clk);
        #1;
        A = ~a; B = ~b; opcode = ~op;
        lat = -1;
        res = 16'hxxxx;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                res = result;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; A = '0; B = '0; opcode = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic [15:0] res;
        run_op(C_ADD, 8'd200, 8'd100, lat, res);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_checks++;
        if (res !== 16'd300) begin n_fail++; $display("FAIL add_result: got %0d expected 300", res); end
    endtask

    task automatic test_sub_not();
        int lat; logic [15:0] res;
        run_op(C_SUB, 8'd3, 8'd5, lat, res);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL sub_latency: got %0d expected 1", lat); end
        n_checks++;
        if (res !== 16'hFFFE) begin n_fail++; $display("FAIL sub_result: got %h expected fffe", res); end
        run_op(C_NOT, 8'h0F, 8'h55, lat, res);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL not_latency: got %0d expected 1", lat); end
        n_checks++;
        if (res !== 16'hFFF0) begin n_fail++; $display("FAIL not_result: got %h expected fff0", res); end
    endtask

    task automatic test_logic();
        int lat; logic [15:0] res;
        run_op(C_XOR, 8'hAA, 8'h0F, lat, res);
        n_checks++;
        if (res !== 16'h00A5) begin n_fail++; $display("FAIL xor_result: got %h expected 00a5", res); end
        run_op(C_AND, 8'hF0, 8'h3C, lat, res);
        n_checks++;
        if (res !== 16'h0030) begin n_fail++; $display("FAIL and_result: got %h expected 0030", res); end
    endtask

    task automatic test_mul();
        int lat; logic [15:0] res;
        run_op(C_MUL, 8'd255, 8'd255, lat, res);
        n_checks++;
        if (lat !== EXP_MUL_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, EXP_MUL_LAT); end
        n_checks++;
        if (res !== EXP_MUL_RES) begin n_fail++; $display("FAIL mul_result: got %0d expected %0d", res, EXP_MUL_RES); end
        run_op(C_MUL, 8'd12, 8'd13, lat, res);
        n_checks++;
`ifdef TINY_ALU_MUL_EN
        if (res !== 16'd156) begin n_fail++; $display("FAIL mul_small_result: got %0d expected 156", res); end
`else
        if (res !== 16'd0) begin n_fail++; $display("FAIL mul_small_result: got %0d expected 0", res); end
`endif
    endtask

    task automatic test_inc_nop();
        int lat; logic [15:0] res;
        run_op(C_INC, 8'd255, 8'd255, lat, res);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL inc_latency: got %0d expected 1", lat); end
        n_checks++;
        if (res !== 16'd511) begin n_fail++; $display("FAIL inc_result: got %0d expected 511", res); end
        run_op(C_NOP, 8'd5, 8'd6, lat, res);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL nop_latency: got %0d expected 1", lat); end
        n_checks++;
        if (res !== 16'd0) begin n_fail++; $display("FAIL nop_result: got %0d expected 0", res); end
    endtask

    // start held high: first op 1+2 accepted at edge k, done at k+1, start
    // ignored at k+2, second op 10+20 accepted at k+3, done at k+4.
    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; A = 8'd1; B = 8'd2; opcode = C_ADD;
        @(posedge clk);
        #1;
        A = 8'd10; B = 8'd20;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || result !== 16'd3) begin
            n_fail++; $display("FAIL b2b_first: got done=%b result=%0d expected done=1 result=3", done, result);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap1: got done=%b expected 0", done); end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap2: got done=%b expected 0", done); end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || result !== 16'd30) begin
            n_fail++; $display("FAIL b2b_second: got done=%b result=%0d expected done=1 result=30", done, result);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_after: got done=%b expected 0", done); end
    endtask

    task automatic test_reset_mid_mul();
        int lat; int seen; logic [15:0] res;
        @(negedge clk);
        start = 1'b1; A = 8'd255; B = 8'd255; opcode = C_MUL;
        @(posedge clk);
        #1;
        start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_checks++;
        if (result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result: got %h expected 0000", result); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", seen); end
        run_op(C_ADD, 8'd1, 8'd1, lat, res);
        n_checks++;
        if (lat !== 1 || res !== 16'd2) begin
            n_fail++; $display("FAIL midrst_add: got lat=%0d result=%0d expected lat=1 result=2", lat, res);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_sub_not();
        test_logic();
        test_mul();
        test_inc_nop();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
